// File: rtl/pat_fieldbuf.sv
// pat_fieldbuf: ring of packet buffers between the ingress/egress byte streams and the pat core field port.
// Optional feature macro PATBUF_LEN_EN adds buf_len readback and len_we packet trimming.

module pat_fieldbuf #(
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  parameter int buffer_width = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [bufp_width-1:0]          bufp,
  input  logic [fieldp_width-1:0]        fieldp,
  input  logic [fieldp_width-1:0]        fieldwp,
  input  logic [buffer_width-1:0]        field_byte_out,
  input  logic                           field_we,
  output logic [buffer_width-1:0]        field_byte_in,
  input  logic                           buf_done,
  output logic [(1<<bufp_width)-1:0]     buf_full,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [buffer_width-1:0]        in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [buffer_width-1:0]        out_data,
  output logic                           out_last
`ifdef PATBUF_LEN_EN
  ,
  input  logic                           len_we,
  output logic [fieldp_width:0]          buf_len
`endif
);

  localparam int NBUF  = 1 << bufp_width;
  localparam int DEPTH = 1 << fieldp_width;
  localparam int AW    = bufp_width + fieldp_width;

  typedef enum logic [2:0] {S_EMPTY, S_FILL, S_FULL, S_DONE, S_DRAIN} buf_state_e;
  typedef logic [fieldp_width:0] len_t;

  localparam len_t LEN_ONE = len_t'(1);

  buf_state_e                state     [NBUF];
  buf_state_e                state_nxt [NBUF];
  len_t                      len       [NBUF];
  logic [buffer_width-1:0]   mem       [NBUF*DEPTH];

  logic [bufp_width-1:0]     fill_ptr, drain_ptr;
  logic [fieldp_width-1:0]   wcnt;
  len_t                      rcnt;

  logic in_fire, in_end, core_full, core_wr, out_fire, drain_end, drain_start, drain_load;
  logic [AW-1:0] in_addr, wr_addr, rd_addr, dr_addr;

  assign in_ready    = (state[fill_ptr] == S_EMPTY) || (state[fill_ptr] == S_FILL);
  assign in_fire     = in_valid & in_ready;
  assign in_end      = in_fire & (in_last | (wcnt == '1));
  assign core_full   = (state[bufp] == S_FULL);
  assign out_fire    = out_valid & out_ready;
  assign drain_end   = out_fire & out_last;
  assign drain_start = (state[drain_ptr] == S_DONE);
  // Keep loading until every byte of the packet has entered the output register.
  assign drain_load  = (state[drain_ptr] == S_DRAIN) && (rcnt < len[drain_ptr]) &&
                       (!out_valid || out_ready);

  assign in_addr = {fill_ptr, wcnt};
  assign wr_addr = {bufp, fieldwp};
  assign rd_addr = {bufp, fieldp};
  assign dr_addr = {drain_ptr, rcnt[fieldp_width-1:0]};

`ifdef PATBUF_LEN_EN
  logic len_wr;
  assign len_wr  = len_we & core_full;
  assign core_wr = field_we & core_full & ~len_we;
`else
  assign core_wr = field_we & core_full;
`endif

  // Ingress, core release and egress always act on buffers in different states,
  // so each transition can simply overwrite its own entry.
  always_comb begin
    // NOTE: start from the current value so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    if (in_fire)              state_nxt[fill_ptr]  = in_end ? S_FULL : S_FILL;
    if (buf_done && core_full) state_nxt[bufp]     = S_DONE;
    if (drain_start)          state_nxt[drain_ptr] = S_DRAIN;
    if (drain_end)            state_nxt[drain_ptr] = S_EMPTY;
  end

  // NOTE: packet storage has no reset; every byte is written before it can be drained.
  always_ff @(posedge clk) begin
    if (in_fire) mem[in_addr] <= in_data;
    if (core_wr) mem[wr_addr] <= field_byte_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) begin
        state[i] <= S_EMPTY;
        len[i]   <= '0;
      end
      buf_full      <= '0;
      fill_ptr      <= '0;
      drain_ptr     <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      field_byte_in <= '0;
`ifdef PATBUF_LEN_EN
      buf_len       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NBUF; i++) begin
        state[i]    <= state_nxt[i];
        buf_full[i] <= (state[i] == S_FULL);
      end

      if (in_fire) begin
        if (in_end) begin
          len[fill_ptr] <= len_t'(wcnt) + LEN_ONE;
          fill_ptr      <= fill_ptr + bufp_width'(1);
          wcnt          <= '0;
        end else begin
          wcnt <= wcnt + fieldp_width'(1);
        end
      end
`ifdef PATBUF_LEN_EN
      if (len_wr) len[bufp] <= len_t'(fieldwp) + LEN_ONE;
      buf_len <= len[bufp];
`endif

      field_byte_in <= mem[rd_addr];

      if (drain_start)     rcnt <= '0;
      else if (drain_load) rcnt <= rcnt + LEN_ONE;

      if (drain_load) begin
        out_valid <= 1'b1;
        out_data  <= mem[dr_addr];
        out_last  <= (rcnt == len[drain_ptr] - LEN_ONE);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (drain_end) drain_ptr <= drain_ptr + bufp_width'(1);
    end
  end

endmodule
